// File: rtl/axi_rr_arbiter_n.sv
// axi_rr_arbiter_n
// N-requester round-robin arbiter for the AXI4-lite interconnect. One master
// owns the shared slave path until it releases it. A rotating priority pointer
// moves past the last owner, and an optional hold timeout reclaims the path
// from an owner that never releases.

module axi_rr_arbiter_n #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 0
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   req,
  input  logic           reg_release,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic        TO_EN    = (MAX_HOLD != 0);
  localparam logic [15:0] HOLD_LIM = 16'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [0:0]     state;
  logic [IDW-1:0] pri_ptr;
  logic [15:0]    hold_cnt;

  logic           found;
  logic [IDW-1:0] win_id;
  logic [N-1:0]   win_onehot;
  logic [IDW:0]   scan;
  logic [IDW-1:0] next_ptr;
  logic           force_rel;

  // Winner search: first set req bit at or above pri_ptr, wrapping modulo N.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the paths that skip it would infer a latch.
    found      = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    scan       = '0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, pri_ptr} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(N)) scan = scan - (IDW+1)'(N);
      if (!found && req[scan[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = scan[IDW-1:0];
      end
    end
    win_onehot[win_id] = found;
  end

  // Pointer after a release wraps modulo N, so non-power-of-two N works too.
  assign next_ptr  = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
  // A release on the same cycle as the limit counts as a normal release.
  assign force_rel = TO_EN && (hold_cnt == HOLD_LIM) && !reg_release;
  assign busy      = (state == GRANT);

  // Arbitration FSM, registered outputs, pointer and hold counter.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: state is updated with non-blocking assignments so that every read
    // in this block sees the value from before the clock edge.
    if (RST) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      timeout  <= 1'b0;
      pri_ptr  <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            grant    <= win_onehot;
            grant_id <= win_id;
            hold_cnt <= '0;
          end
        end
        default: begin
          if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
          if (reg_release || force_rel) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            pri_ptr  <= next_ptr;
            timeout  <= force_rel;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter_n.sv
// Testbench for axi_rr_arbiter_n: directed scenarios on three instances
// (N=4, N=3, N=4 with MAX_HOLD=5) followed by random traffic compared against
// a behavioural owner/pointer model.

module tb_axi_rr_arbiter_n;

  logic CLK = 1'b0;
  logic RST;

  logic [3:0] req4;  logic rel4;  logic [3:0] g4;  logic [1:0] id4;  logic busy4, to4;
  logic [2:0] req3;  logic rel3;  logic [2:0] g3;  logic [1:0] id3;  logic busy3, to3;
  logic [3:0] reqt;  logic relt;  logic [3:0] gt;  logic [1:0] idt;  logic busyt, tot;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    int owner;  // -1 when nobody holds the bus
    int ptr;
    int held;   // grant cycles already seen by the current owner
    bit to;
  } model_t;

  model_t m4, m3, mt;

  always #5 CLK = ~CLK;

  axi_rr_arbiter_n #(.N(4), .MAX_HOLD(0)) dut4 (
    .CLK(CLK), .RST(RST), .req(req4), .reg_release(rel4),
    .grant(g4), .grant_id(id4), .busy(busy4), .timeout(to4));

  axi_rr_arbiter_n #(.N(3), .MAX_HOLD(0)) dut3 (
    .CLK(CLK), .RST(RST), .req(req3), .reg_release(rel3),
    .grant(g3), .grant_id(id3), .busy(busy3), .timeout(to3));

  axi_rr_arbiter_n #(.N(4), .MAX_HOLD(5)) dutt (
    .CLK(CLK), .RST(RST), .req(reqt), .reg_release(relt),
    .grant(gt), .grant_id(idt), .busy(busyt), .timeout(tot));

  // Behavioural reference: who owns the bus, where the search starts, and how
  // long the owner has had it.
  function automatic model_t model_step(model_t m, int n, int maxh, int rq, bit rel);
    model_t r = m;
    r.to = 1'b0;
    if (m.owner < 0) begin
      for (int k = 0; k < n; k++) begin
        int c = (m.ptr + k) % n;
        if (r.owner < 0 && rq[c]) begin
          r.owner = c;
          r.held  = 1;
        end
      end
    end else if (rel) begin
      r.owner = -1;
      r.ptr   = (m.owner + 1) % n;
    end else if (maxh != 0 && m.held >= maxh) begin
      r.owner = -1;
      r.ptr   = (m.owner + 1) % n;
      r.to    = 1'b1;
    end else begin
      r.held = m.held + 1;
    end
    return r;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1;
    r.ptr   = 0;
    r.held  = 0;
    r.to    = 1'b0;
    return r;
  endfunction

  // One clock: inputs already driven, sampled at the rising edge, outputs
  // observed on the following falling edge.
  task automatic step();
    @(posedge CLK);
    m4 = model_step(m4, 4, 0, int'(req4), rel4);
    m3 = model_step(m3, 3, 0, int'(req3), rel3);
    mt = model_step(mt, 4, 5, int'(reqt), relt);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    req4 = '0; rel4 = 1'b0;
    req3 = '0; rel3 = 1'b0;
    reqt = '0; relt = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    m4 = model_reset();
    m3 = model_reset();
    mt = model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    req4 = 4'b1111; rel4 = 1'b0;
    req3 = 3'b111;  rel3 = 1'b0;
    reqt = 4'b1111; relt = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_vec++; if ({g4, id4, busy4, to4} !== 8'h00) begin
      n_mis++; $display("FAIL reset_n4: got %b want 00000000", {g4, id4, busy4, to4});
    end
    n_vec++; if ({g3, id3, busy3, to3} !== 7'h00) begin
      n_mis++; $display("FAIL reset_n3: got %b want 0000000", {g3, id3, busy3, to3});
    end
    n_vec++; if ({gt, idt, busyt, tot} !== 8'h00) begin
      n_mis++; $display("FAIL reset_to: got %b want 00000000", {gt, idt, busyt, tot});
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    req4 = 4'b0100;
    step();
    n_vec++; if ({g4, id4, busy4} !== {4'b0100, 2'd2, 1'b1}) begin
      n_mis++; $display("FAIL basic_grant: got g=%b id=%0d busy=%b want g=0100 id=2 busy=1", g4, id4, busy4);
    end
    rel4 = 1'b1;
    step();
    rel4 = 1'b0;
    req4 = 4'b0000;
    n_vec++; if ({g4, id4, busy4, to4} !== 8'h00) begin
      n_mis++; $display("FAIL basic_release: got %b want 00000000", {g4, id4, busy4, to4});
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply_reset();
    req4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rel4 = 1'b0;
      step();
      n_vec++; if (g4 !== seq[k]) begin
        n_mis++; $display("FAIL rotation_grant%0d: got %b want %b", k, g4, seq[k]);
      end
      step();
      n_vec++; if (g4 !== seq[k]) begin
        n_mis++; $display("FAIL rotation_hold%0d: got %b want %b", k, g4, seq[k]);
      end
      rel4 = 1'b1;
      step();
      n_vec++; if (g4 !== 4'b0000) begin
        n_mis++; $display("FAIL rotation_gap%0d: got %b want 0000", k, g4);
      end
    end
    rel4 = 1'b0;
    req4 = '0;
  endtask

  task automatic test_wrap_n3();
    apply_reset();
    req3 = 3'b100;
    step();
    n_vec++; if ({g3, id3} !== {3'b100, 2'd2}) begin
      n_mis++; $display("FAIL wrap_first: got g=%b id=%0d want g=100 id=2", g3, id3);
    end
    req3 = 3'b000; rel3 = 1'b1;
    step();
    rel3 = 1'b0; req3 = 3'b110;
    step();
    n_vec++; if ({g3, id3} !== {3'b010, 2'd1}) begin
      n_mis++; $display("FAIL wrap_skip: got g=%b id=%0d want g=010 id=1", g3, id3);
    end
    req3 = 3'b000; rel3 = 1'b1;
    step();
    rel3 = 1'b0; req3 = 3'b001;
    step();
    n_vec++; if ({g3, id3} !== {3'b001, 2'd0}) begin
      n_mis++; $display("FAIL wrap_around: got g=%b id=%0d want g=001 id=0", g3, id3);
    end
    req3 = '0; rel3 = 1'b1;
    step();
    rel3 = 1'b0;
  endtask

  task automatic test_drop_and_idle_release();
    apply_reset();
    req4 = 4'b0010;
    step();
    req4 = 4'b0000;
    step();
    step();
    n_vec++; if ({g4, id4, busy4} !== {4'b0010, 2'd1, 1'b1}) begin
      n_mis++; $display("FAIL drop_hold: got g=%b id=%0d busy=%b want g=0010 id=1 busy=1", g4, id4, busy4);
    end
    rel4 = 1'b1;
    step();
    n_vec++; if (g4 !== 4'b0000) begin
      n_mis++; $display("FAIL drop_release: got %b want 0000", g4);
    end
    step();
    rel4 = 1'b0;
    n_vec++; if ({g4, id4, busy4, to4} !== 8'h00) begin
      n_mis++; $display("FAIL idle_release: got %b want 00000000", {g4, id4, busy4, to4});
    end
    req4 = 4'b1111;
    step();
    n_vec++; if (g4 !== 4'b0100) begin
      n_mis++; $display("FAIL idle_release_ptr: got %b want 0100", g4);
    end
    req4 = '0; rel4 = 1'b1;
    step();
    rel4 = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    reqt = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if ({gt, tot} !== {4'b0010, 1'b0}) begin
        n_mis++; $display("FAIL timeout_hold%0d: got g=%b to=%b want g=0010 to=0", k, gt, tot);
      end
    end
    step();
    n_vec++; if ({gt, busyt, tot} !== {4'b0000, 1'b0, 1'b1}) begin
      n_mis++; $display("FAIL timeout_fire: got g=%b busy=%b to=%b want g=0000 busy=0 to=1", gt, busyt, tot);
    end
    reqt = 4'b0011;
    step();
    n_vec++; if ({gt, tot} !== {4'b0001, 1'b0}) begin
      n_mis++; $display("FAIL timeout_ptr: got g=%b to=%b want g=0001 to=0", gt, tot);
    end
    for (int k = 0; k < 4; k++) step();
    relt = 1'b1;
    step();
    relt = 1'b0;
    reqt = 4'b0000;
    n_vec++; if ({gt, tot} !== {4'b0000, 1'b0}) begin
      n_mis++; $display("FAIL timeout_coincide: got g=%b to=%b want g=0000 to=0", gt, tot);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req4 = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      rel4 = 1'b1;
      step();
      rel4 = 1'b0;
    end
    req4 = 4'b1000;
    step();
    n_vec++; if (g4 !== 4'b1000) begin
      n_mis++; $display("FAIL areset_setup: got %b want 1000", g4);
    end
    #2 RST = 1'b1;
    #1;
    n_vec++; if ({g4, id4, busy4, to4} !== 8'h00) begin
      n_mis++; $display("FAIL areset_immediate: got %b want 00000000", {g4, id4, busy4, to4});
    end
    req4 = 4'b1001;
    @(negedge CLK);
    RST = 1'b0;
    m4 = model_reset();
    step();
    n_vec++; if ({g4, id4} !== {4'b0001, 2'd0}) begin
      n_mis++; $display("FAIL areset_ptr: got g=%b id=%0d want g=0001 id=0", g4, id4);
    end
    req4 = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      req4 = 4'($urandom);
      req3 = 3'($urandom);
      reqt = 4'($urandom);
      rel4 = ($urandom_range(0, 3) == 0);
      rel3 = ($urandom_range(0, 2) == 0);
      relt = ($urandom_range(0, 7) == 0);
      step();
      n_vec++; if ({g4, id4, busy4, to4} !== {(m4.owner < 0) ? 4'b0 : 4'(1 << m4.owner),
                                             (m4.owner < 0) ? 2'd0 : 2'(m4.owner),
                                             (m4.owner >= 0), m4.to}) begin
        n_mis++; $display("FAIL random_n4 cyc %0d: got g=%b id=%0d busy=%b to=%b want owner=%0d to=%b",
                          k, g4, id4, busy4, to4, m4.owner, m4.to);
      end
      n_vec++; if ({g3, id3, busy3, to3} !== {(m3.owner < 0) ? 3'b0 : 3'(1 << m3.owner),
                                             (m3.owner < 0) ? 2'd0 : 2'(m3.owner),
                                             (m3.owner >= 0), m3.to}) begin
        n_mis++; $display("FAIL random_n3 cyc %0d: got g=%b id=%0d busy=%b to=%b want owner=%0d to=%b",
                          k, g3, id3, busy3, to3, m3.owner, m3.to);
      end
      n_vec++; if ({gt, idt, busyt, tot} !== {(mt.owner < 0) ? 4'b0 : 4'(1 << mt.owner),
                                             (mt.owner < 0) ? 2'd0 : 2'(mt.owner),
                                             (mt.owner >= 0), mt.to}) begin
        n_mis++; $display("FAIL random_to cyc %0d: got g=%b id=%0d busy=%b to=%b want owner=%0d to=%b",
                          k, gt, idt, busyt, tot, mt.owner, mt.to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_wrap_n3();
    test_drop_and_idle_release();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter_n.md
# axi_rr_arbiter_n

Parametrised N-requester round-robin arbiter for the AXI4-lite interconnect. It is the multi-master successor of the two-requester arbiter. It grants the shared slave path to one master at a time and holds that grant until the master releases it. Fairness comes from a rotating priority pointer that advances past the last winner. An optional hold-timeout forcibly reclaims the bus from a master that never releases.

## Interface
- N, default 4: number of requesters, legal range 2..16.
- IDW, default $clog2(N): width of grant_id. Derived; do not override.
- MAX_HOLD, default 0: maximum cycles a grant may be held. 0 disables the timeout. Legal range 0..65535.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  N  request vector, one bit per master. Level-sensitive.
- reg_release  in  1  the current owner has finished; meaningful only while busy=1.
- grant  out  N  one-hot grant, registered. All zero when no owner.
- grant_id  out  IDW  binary index of the owner, registered. Holds 0 when grant is zero.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse, registered, marking a forced release.

## Operation
- FSM states are IDLE and GRANT. On reset the FSM is in IDLE, grant=0, grant_id=0, busy=0, timeout=0, pri_ptr=0, hold_cnt=0.
- **IDLE**
  - If |req, pick the winner: the first set bit of req found by searching upward from index pri_ptr, wrapping modulo N.
  - The winner is loaded into grant/grant_id and the FSM moves to GRANT.
  - If req=0, the FSM stays in IDLE. reg_release is ignored in IDLE.
- **GRANT**
  - grant and grant_id are frozen; req changes are ignored, including the owner dropping its own req.
  - hold_cnt increments every cycle.
  - If reg_release=1, the FSM goes to IDLE, grant clears, and pri_ptr becomes (grant_id+1) mod N.
  - If MAX_HOLD≠0, hold_cnt==MAX_HOLD-1 and reg_release=0, a forced release occurs with the same transition and pointer update, and timeout=1 for the next cycle only.
  - reg_release=1 on the same cycle as the timeout condition counts as a normal release; timeout stays 0.
- Pointer arithmetic is modulo N, including non-power-of-two N. For example, with N=3 and grant_id=2, the pointer wraps to 0.
- hold_cnt is 16 bits wide and clears on entry to GRANT. It cannot overflow while MAX_HOLD=0 because it saturates at 0xFFFF.
- The winner search is combinational over N bits, built as a double-width masked priority encode or an equivalent loop. Only the outputs listed above are registered.

## Timing
- Arbitration latency is 1 cycle: a req sampled in IDLE on edge t produces grant valid after edge t+1.
- Release latency is 1 cycle: reg_release sampled on edge t clears grant after edge t+1.
- Every grant is followed by one mandatory IDLE cycle.
  - Minimum spacing between successive grants is 2 cycles.
  - Back-to-back requesters therefore see grant patterns of the form A,0,B,0,...
- With a timeout, grant stays high for exactly MAX_HOLD cycles. timeout is high in the first cycle that grant=0.
- Asserting RST at any point, including mid-GRANT, immediately forces all outputs to their reset values. The pointer also returns to 0.
- The first edge after RST deasserts performs a normal IDLE evaluation.

## Test plan
- **Basic grant/release** (N=4): reset, then req=0100 → grant=0100 and grant_id=2 one cycle later. Pulse reg_release → grant=0000 and busy=0 one cycle later.
- **Rotation fairness**: hold req=1111 and release each grant after 2 cycles. Grants must cycle 0001,0010,0100,1000,0001, each separated by one zero cycle.
- **Pointer wrap and skipping** (N=3, non-power-of-two): after owner 2 releases, drive req=110 → grant=010, not 100. Then req=001 → grant=001.
- **Owner drops req / release in IDLE**: the owner deasserts req while granted → grant holds until reg_release. A reg_release pulse in IDLE with req=0 → no state change.
- **Timeout** (MAX_HOLD=5): owner 1 never releases → grant=0010 for exactly 5 cycles, then grant=0000 with timeout=1 for one cycle. Then req=0011 → grant=0001, because the pointer has advanced to 2 and wrapped.
- **Async reset mid-GRANT**: assert RST between clock edges while grant=1000 → grant, grant_id, busy and timeout go to 0 before the next edge. After RST deasserts with req=1001, the grant is 0001 because the pointer is back at 0.
